// File: rtl/mem_pkg.sv
// Shared types and constants for the SRAM controller slice.
// Holds the controller FSM encoding and the byte-lane width.
package mem_pkg;

  localparam int LANE_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/mem_array_1rw.sv
// Single-port word array with per-byte write enables and a registered read port.
// Storage only: no reset, no range checking (the controller keeps addresses in range).
module mem_array_1rw
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DATA_W/LANE_W-1:0] be,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  localparam int BE_W = DATA_W / LANE_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array or its read register; contents are zeroed by the controller's clear sweep, which keeps this mappable to a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_sram_ctrl.sv
// Valid/ready front end for mem_array_1rw: clear sweep FSM, write mux,
// address range check and one-cycle read response path.
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  inout  wire                      dvdd,
  inout  wire                      dgnd,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DATA_W/LANE_W-1:0] req_be,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err
);

  localparam int BE_W = DATA_W / LANE_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              clr_last;
  logic              accept;
  logic              in_range;

  logic              arr_we;
  logic [BE_W-1:0]   arr_be;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rdata_hold_q;

  // Supply pins are physical-only; tie them into a sink so they are not dangling.
  logic unused_supply;
  assign unused_supply = dvdd ^ dgnd;

  // Compare at 32 bits so DEPTH == 2**ADDR_W does not wrap to zero.
  assign in_range  = 32'(req_addr) < DEPTH;
  assign clr_last  = (clr_addr_q == ADDR_W'(DEPTH - 1));
  assign req_ready = (state_q == ST_IDLE) && !clr_req;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q == ST_CLEAR);

  // NOTE: every always_comb output gets a default before any branch so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_last) state_d = ST_IDLE;
      ST_IDLE:  if (clr_req)  state_d = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) begin
        clr_addr_q <= clr_last ? '0 : clr_addr_q + ADDR_W'(1);
      end else if (clr_req) begin
        clr_addr_q <= '0;
      end
    end
  end

  // The sweep owns the array port while clearing; out-of-range writes are dropped here.
  always_comb begin
    arr_we    = accept && req_we && in_range;
    arr_be    = req_be;
    arr_addr  = req_addr;
    arr_wdata = req_wdata;
    if (state_q == ST_CLEAR) begin
      arr_we    = 1'b1;
      arr_be    = '1;
      arr_addr  = clr_addr_q;
      arr_wdata = '0;
    end
  end

  mem_array_1rw #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      rsp_valid_q <= accept && !req_we;
      rsp_err_q   <= accept && !req_we && !in_range;
      if (rsp_valid_q) rdata_hold_q <= rsp_rdata;
    end
  end

  // Array read data is live only in the response cycle; afterwards the captured copy is shown.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_valid_q ? (rsp_err_q ? '0 : arr_rdata) : rdata_hold_q;

endmodule
